zfsoc_debug_ocimem: RTL and testbench
=====================================

# zfsoc_debug_ocimem

Debug on-chip memory and monitor-handshake block for the Nios II debug path. It consumes the system-clock-domain outputs of the debug slave (`jdo`, `take_action_ocimem_a/b`, `take_no_action_ocimem_a`) and executes JTAG-issued reads and writes into a private debug RAM. It returns read data and monitor status (`MonDReg`, `monitor_ready`, `monitor_error`) to the debug slave. It also exposes the same RAM and a control register to the CPU through an Avalon-MM slave.

## Interface
- `ADDR_W`, default 8: RAM word-address width (depth 2^ADDR_W words of 32 bits); legal range 4..10.
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high reset.
- `jdo`  in  38  debug command/data word from the debug slave.
- `take_action_ocimem_a`  in  1  one-cycle pulse: load address / control command.
- `take_no_action_ocimem_a`  in  1  one-cycle pulse: read at current address, then post-increment.
- `take_action_ocimem_b`  in  1  one-cycle pulse: write at current address, then post-increment.
- `avs_address`  in  ADDR_W+1  bit ADDR_W=1 selects the control register; otherwise a RAM word address.
- `avs_read`, `avs_write`  in  1  Avalon strobes.
- `avs_writedata`  in  32; `avs_byteenable`  in  4; `avs_debugaccess`  in  1.
- `avs_readdata`  out  32; `avs_waitrequest`  out  1.
- `MonDReg`  out  32  last JTAG read result.
- `monitor_ready`, `monitor_error`, `monitor_go`  out  1  monitor status flags.

## Operation
- MonAReg is an internal ADDR_W-bit address register.
- **take_action_ocimem_a:**
  - MonAReg <= jdo[26+ADDR_W-1:26].
  - jdo[25]=1 clears monitor_ready and monitor_error.
  - jdo[24]=1 sets monitor_go.
  - jdo[17]=1 also issues a read at the new address, then post-increments MonAReg.
- **take_no_action_ocimem_a:** read at MonAReg, then MonAReg+1.
- **take_action_ocimem_b:** write jdo[34:3] at MonAReg with all bytes enabled, then MonAReg+1.
- MonAReg wraps from 2^ADDR_W-1 to 0.
- Pulse precedence: if both a-type and b pulses arrive in the same cycle, the a-type pulse executes and b is dropped. These pulses are mutually exclusive upstream.
- RAM port arbitration: one access per cycle; JTAG always has priority. A CPU request coinciding with a JTAG pulse is held off (waitrequest=1) and retried the next cycle.
- **CPU RAM FSM:**
  - C_IDLE: on an RAM read that is not preempted, issue the read and go to C_RD_WAIT.
  - C_RD_WAIT: capture RAM q into the readdata register, go to C_RD_DONE.
  - C_RD_DONE: waitrequest=0, return to C_IDLE.
- **CPU RAM writes:** complete in the grant cycle with waitrequest=0 and the given byteenable. If avs_debugaccess=0, the write is acknowledged but the RAM is not modified.
- **Control register:**
  - Read returns {29'b0, monitor_go, monitor_error, monitor_ready} with waitrequest=0 in the same cycle.
  - Write: writedata bit0=1 sets monitor_ready, bit1=1 sets monitor_error, bit2=1 clears monitor_go.
  - Control access never waits on JTAG.
- Simultaneous JTAG clear (jdo[25]) and CPU set: the set wins.
- Simultaneous JTAG set-go and CPU clear-go: the set wins.

## Timing
- **Reset:** MonDReg=0, monitor_*=0, avs_readdata=0, avs_waitrequest=0, MonAReg=0, FSM=C_IDLE. RAM contents are not initialised.
- **JTAG write:** RAM is updated at the rising edge that ends the pulse cycle. MonAReg increments at the same edge.
- **JTAG read:** the RAM is addressed in the pulse cycle. MonDReg holds the data from the second rising edge after the pulse edge (latency 2). A pulse arriving before the previous read lands is legal; results land in order.
- **CPU RAM read:** waitrequest is high for 2 cycles after an unpreempted request, then low for 1 cycle with readdata valid. Each preempted cycle adds 1 cycle of latency.
- **Reset mid-operation:** an in-flight read is abandoned; no MonDReg update and no readdata strobe after release.

## Structure
- **Shared package:**
  - jdo field constants: JDO_ADDR_LSB=26, JDO_CLR_BIT=25, JDO_GO_BIT=24, JDO_RD_BIT=17, JDO_WDATA_LSB=3.
  - Control-register bit indices.
  - CPU FSM state enum.
- **Sub-module:** `zfsoc_debug_ocimem_ram`, a single-port synchronous RAM with byte enables, 1-cycle read latency, no reset.

## Test plan
- Load address: a-pulse with jdo[33:26]=0x10, jdo[17]=0, then b-pulses with 0xDEADBEEF and 0x12345678. CPU reads word 0x10 -> 0xDEADBEEF; word 0x11 -> 0x12345678.
- Post-increment read: a-pulse with address 0x10 and jdo[17]=1, then a no_action pulse. MonDReg=0xDEADBEEF 2 edges after the first pulse; then 0x12345678.
- Wrap: a-pulse with address 0xFF, then two b-pulses. Words 0xFF and 0x00 are written; MonAReg ends at 0x01.
- Collision: CPU read of word 5 asserted in the same cycle as a b-pulse. waitrequest stays high 3 cycles; readdata is the pre-write or post-write value consistent with write-then-read ordering.
- Flags: CPU writes control=0x3, then an a-pulse with jdo[25]=1 and jdo[24]=1. Control reads 0x4. A CPU write of 0x4 in the same cycle as an a-pulse with jdo[24]=1 leaves monitor_go=1.
- debugaccess=0: CPU write of 0xFFFFFFFF to word 2 leaves it unchanged. Asserting reset during a pending CPU read forces all outputs to 0.

Source files
------------

// File: rtl/zfsoc_debug_ocimem_pkg.sv
// zfsoc_debug_ocimem shared definitions:
// jdo field positions, control bits, CPU FSM states.
package zfsoc_debug_ocimem_pkg;

  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_CLR_BIT   = 25;
  localparam int JDO_GO_BIT    = 24;
  localparam int JDO_RD_BIT    = 17;
  localparam int JDO_WDATA_LSB = 3;

  localparam int CTRL_RDY_BIT = 0;
  localparam int CTRL_ERR_BIT = 1;
  localparam int CTRL_GO_BIT  = 2;

  typedef enum logic [1:0] {
    C_IDLE,
    C_RD_WAIT,
    C_RD_DONE
  } cpu_state_e;

endpackage

// File: rtl/zfsoc_debug_ocimem_ram.sv
// Single-port debug RAM, byte enables,
// registered read data, contents not reset.
module zfsoc_debug_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  // Byte-masked write plus read of the old word at the same address
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/zfsoc_debug_ocimem.sv
// Debug on-chip memory: JTAG monitor access
// and CPU Avalon slave sharing one RAM port.
module zfsoc_debug_ocimem
  import zfsoc_debug_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              monitor_go
);

  cpu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q;
  logic              jrd_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic              go_q, go_d;

  logic              j_a, j_na, j_b, j_busy, j_rd;
  logic [ADDR_W-1:0] jdo_addr, j_addr;
  logic              ctrl_sel, ctrl_rd, ctrl_wr;
  logic              cpu_we, wait_c;
  logic [31:0]       ctrl_val;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_q;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // a-type pulses win; b only runs when alone
  assign j_a    = take_action_ocimem_a;
  assign j_na   = take_no_action_ocimem_a & ~j_a;
  assign j_b    = take_action_ocimem_b & ~j_a
                & ~take_no_action_ocimem_a;
  assign j_busy = take_action_ocimem_a
                | take_no_action_ocimem_a
                | take_action_ocimem_b;
  assign j_rd   = (j_a & jdo[JDO_RD_BIT]) | j_na;

  assign jdo_addr = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign j_addr   = j_a ? jdo_addr : mon_a_q;

  assign ctrl_sel = avs_address[ADDR_W];
  assign ctrl_rd  = avs_read & ctrl_sel;
  assign ctrl_wr  = avs_write & ctrl_sel;

  // Monitor address: load on a-pulse, post-increment on each access
  always_comb begin
    mon_a_d = mon_a_q;
    if (j_a) begin
      mon_a_d = jdo_addr + ADDR_W'(jdo[JDO_RD_BIT]);
    end else if (j_na | j_b) begin
      mon_a_d = mon_a_q + 1'b1;
    end
  end

  // Flags: JTAG clear/CPU set, CPU clear/JTAG set; set wins both
  always_comb begin
    rdy_d = rdy_q;
    err_d = err_q;
    go_d  = go_q;
    if (j_a && jdo[JDO_CLR_BIT]) begin
      rdy_d = 1'b0;
      err_d = 1'b0;
    end
    if (ctrl_wr && avs_writedata[CTRL_RDY_BIT]) rdy_d = 1'b1;
    if (ctrl_wr && avs_writedata[CTRL_ERR_BIT]) err_d = 1'b1;
    if (ctrl_wr && avs_writedata[CTRL_GO_BIT])  go_d  = 1'b0;
    if (j_a && jdo[JDO_GO_BIT])                 go_d  = 1'b1;
  end

  // CPU RAM access FSM; JTAG pulses hold it off
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    cpu_we  = 1'b0;
    wait_c  = 1'b0;
    unique case (state_q)
      C_IDLE: begin
        if (avs_read && !ctrl_sel) begin
          wait_c = 1'b1;
          if (!j_busy) state_d = C_RD_WAIT;
        end else if (avs_write && !ctrl_sel) begin
          if (j_busy) wait_c = 1'b1;
          else        cpu_we = avs_debugaccess;
        end
      end
      C_RD_WAIT: begin
        wait_c  = 1'b1;
        rdata_d = ram_q;
        state_d = C_RD_DONE;
      end
      C_RD_DONE: begin
        state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  // Control register image
  always_comb begin
    ctrl_val = '0;
    ctrl_val[CTRL_RDY_BIT] = rdy_q;
    ctrl_val[CTRL_ERR_BIT] = err_q;
    ctrl_val[CTRL_GO_BIT]  = go_q;
  end

  // RAM port mux: JTAG owns the port whenever it pulses
  assign ram_we    = j_b | cpu_we;
  assign ram_be    = j_b ? 4'hF : avs_byteenable;
  assign ram_addr  = j_busy ? j_addr
                   : avs_address[ADDR_W-1:0];
  assign ram_wdata = j_b ? jdo[JDO_WDATA_LSB +: 32]
                   : avs_writedata;

  zfsoc_debug_ocimem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_q)
  );

  // State, address, flags and the JTAG read pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= C_IDLE;
      mon_a_q <= '0;
      mon_d_q <= '0;
      jrd_q   <= 1'b0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mon_a_q <= mon_a_d;
      jrd_q   <= j_rd;
      if (jrd_q) mon_d_q <= ram_q;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      go_q    <= go_d;
    end
  end

  assign avs_readdata    = ctrl_rd ? ctrl_val : rdata_q;
  assign avs_waitrequest = wait_c;
  assign MonDReg         = mon_d_q;
  assign monitor_ready   = rdy_q;
  assign monitor_error   = err_q;
  assign monitor_go      = go_q;

endmodule

// File: tb/tb_zfsoc_debug_ocimem.sv
// Scoreboard bench for zfsoc_debug_ocimem:
// directed JTAG and Avalon traffic.
module tb_zfsoc_debug_ocimem;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [8:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_debugaccess;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, monitor_go;

  int checks = 0;
  int errors = 0;
  logic [31:0] jq[$];
  logic [31:0] cq[$];
  logic p1, p2;
  int w;

  localparam logic [8:0] CTRL = 9'h100;

  zfsoc_debug_ocimem #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_debugaccess         (avs_debugaccess),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .monitor_go              (monitor_go)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Track JTAG read issue so MonDReg is checked two edges later
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      p1 <= (take_action_ocimem_a & jdo[17])
          | take_no_action_ocimem_a;
      p2 <= p1;
    end
  end

  // Monitor: pop expectations when DUT presents results
  always @(negedge clk) begin
    if (avs_read && !avs_waitrequest) begin
      if (cq.size() == 0) begin
        checks++; errors++;
        $display("FAIL cpu_rdata: got %h expected none",
                 avs_readdata);
      end else chk("cpu_rdata", avs_readdata, cq.pop_front());
    end
    if (p2) begin
      if (jq.size() == 0) begin
        checks++; errors++;
        $display("FAIL MonDReg: got %h expected none", MonDReg);
      end else chk("MonDReg", MonDReg, jq.pop_front());
    end
  end

  task automatic jtag_a(input logic [7:0] addr, input logic clr,
                        input logic go, input logic rd,
                        input logic [31:0] exp);
    jdo = '0;
    jdo[33:26] = addr;
    jdo[25] = clr;
    jdo[24] = go;
    jdo[17] = rd;
    if (rd) jq.push_back(exp);
    take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    jdo = '0;
  endtask

  task automatic jtag_na(input logic [31:0] exp);
    jq.push_back(exp);
    take_no_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_b(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
    jdo = '0;
  endtask

  task automatic cpu_read(input logic [8:0] addr,
                          input logic [31:0] exp,
                          output int waits);
    cq.push_back(exp);
    avs_address = addr;
    avs_read = 1'b1;
    waits = 0;
    @(negedge clk);
    while (avs_waitrequest && waits <= 20) begin
      waits++;
      @(negedge clk);
    end
    if (waits > 20) begin
      checks++; errors++;
      $display("FAIL cpu_read_timeout: got %0d expected <=20", waits);
    end
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic cpu_write(input logic [8:0] addr,
                           input logic [31:0] d,
                           input logic [3:0] be,
                           input logic dbg);
    int n;
    avs_address = addr;
    avs_writedata = d;
    avs_byteenable = be;
    avs_debugaccess = dbg;
    avs_write = 1'b1;
    n = 0;
    @(negedge clk);
    while (avs_waitrequest && n <= 20) begin
      n++;
      @(negedge clk);
    end
    if (n > 20) begin
      checks++; errors++;
      $display("FAIL cpu_write_timeout: got %0d expected <=20", n);
    end
    @(posedge clk); #1;
    avs_write = 1'b0;
    avs_debugaccess = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    avs_byteenable = 4'hF;
    avs_debugaccess = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_rdata", avs_readdata, 32'h0);
    chk("rst_wait", {31'b0, avs_waitrequest}, 32'h0);
    chk("rst_flags", {29'b0, monitor_go, monitor_error,
        monitor_ready}, 32'h0);
    @(posedge clk); #1;

    // Load address and JTAG writes
    jtag_a(8'h10, 1'b0, 1'b0, 1'b0, 32'h0);
    jtag_b(32'hDEADBEEF);
    jtag_b(32'h12345678);
    cpu_read(9'h010, 32'hDEADBEEF, w);
    chk("rd_waits", w, 2);
    cpu_read(9'h011, 32'h12345678, w);

    // Post-increment JTAG reads, back to back
    jtag_a(8'h10, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    jtag_na(32'h12345678);
    repeat (3) @(posedge clk);
    #1;

    // Wrap: FF then 00, MonAReg lands on 01
    cpu_write(9'h001, 32'hCAFEF00D, 4'hF, 1'b1);
    jtag_a(8'hFF, 1'b0, 1'b0, 1'b0, 32'h0);
    jtag_b(32'hA5A5A5A5);
    jtag_b(32'h5A5A5A5A);
    jtag_na(32'hCAFEF00D);
    cpu_read(9'h0FF, 32'hA5A5A5A5, w);
    cpu_read(9'h000, 32'h5A5A5A5A, w);

    // Collision: CPU read of word 5 during a JTAG write to word 5
    cpu_write(9'h005, 32'h0BADF00D, 4'hF, 1'b1);
    jtag_a(8'h05, 1'b0, 1'b0, 1'b0, 32'h0);
    fork
      jtag_b(32'h600DCAFE);
      cpu_read(9'h005, 32'h600DCAFE, w);
    join
    chk("coll_waits", w, 3);

    // Byte-enabled CPU write
    cpu_write(9'h005, 32'hFFFFFFFF, 4'b0001, 1'b1);
    cpu_read(9'h005, 32'h600DCAFF, w);

    // Control register and flag races
    cpu_write(CTRL, 32'h3, 4'hF, 1'b1);
    cpu_read(CTRL, 32'h3, w);
    chk("ctrl_waits", w, 0);
    jtag_a(8'h00, 1'b1, 1'b1, 1'b0, 32'h0);
    cpu_read(CTRL, 32'h4, w);
    chk("go_pin", {31'b0, monitor_go}, 32'h1);
    cpu_write(CTRL, 32'h4, 4'hF, 1'b1);
    cpu_read(CTRL, 32'h0, w);
    fork
      cpu_write(CTRL, 32'h4, 4'hF, 1'b1);
      jtag_a(8'h00, 1'b0, 1'b1, 1'b0, 32'h0);
    join
    cpu_read(CTRL, 32'h4, w);
    fork
      cpu_write(CTRL, 32'h1, 4'hF, 1'b1);
      jtag_a(8'h00, 1'b1, 1'b0, 1'b0, 32'h0);
    join
    cpu_read(CTRL, 32'h5, w);
    chk("rdy_pin", {31'b0, monitor_ready}, 32'h1);

    // debugaccess=0 write is dropped
    cpu_write(9'h002, 32'h22222222, 4'hF, 1'b1);
    cpu_write(9'h002, 32'hFFFFFFFF, 4'hF, 1'b0);
    cpu_read(9'h002, 32'h22222222, w);

    // Reset with a CPU read pending and a JTAG read in flight
    avs_address = 9'h003;
    avs_read = 1'b1;
    take_no_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_no_action_ocimem_a = 1'b0;
    reset = 1'b1;
    avs_read = 1'b0;
    @(negedge clk);
    chk("mrst_MonDReg", MonDReg, 32'h0);
    chk("mrst_rdata", avs_readdata, 32'h0);
    chk("mrst_wait", {31'b0, avs_waitrequest}, 32'h0);
    chk("mrst_flags", {29'b0, monitor_go, monitor_error,
        monitor_ready}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_MonDReg", MonDReg, 32'h0);
    chk("post_rdata", avs_readdata, 32'h0);
    chk("jq_empty", jq.size(), 0);
    chk("cq_empty", cq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
